// File: rtl/onehot_enc_tree.sv
// rtl/onehot_enc_tree.sv - registered one-hot to binary encoder built from SPLIT-input priority nodes
// Optional input register stage: define ONEHOT_ENC_TREE_IN_REG_EN (latency becomes 2).
module onehot_enc_tree #(
  parameter int WIDTH          = 16,
  parameter int SPLIT          = 4,
  parameter int IMPLEMENTATION = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         dec_vld,
  output logic [$clog2(WIDTH)-1:0] enc_idx,
  output logic                     enc_vld
);

  localparam int WIDTH_LOG = $clog2(WIDTH);
  localparam int SPLIT_LOG = $clog2(SPLIT);
  localparam int LEVELS    = (WIDTH_LOG + SPLIT_LOG - 1) / SPLIT_LOG;
  localparam int IW        = SPLIT_LOG * LEVELS;
  localparam int PW        = 1 << IW;

  generate
    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
      $fatal(1, "onehot_enc_tree: WIDTH must be a power of two >= 2");
    end
    if (SPLIT < 2 || (SPLIT & (SPLIT - 1)) != 0) begin : g_bad_split
      $fatal(1, "onehot_enc_tree: SPLIT must be a power of two >= 2");
    end
    if (SPLIT > WIDTH) begin : g_bad_split_width
      $fatal(1, "onehot_enc_tree: SPLIT must not exceed WIDTH");
    end
    if (IMPLEMENTATION < 0 || IMPLEMENTATION > 4) begin : g_bad_impl
      $fatal(1, "onehot_enc_tree: IMPLEMENTATION must be 0..4");
    end
  endgenerate

  // Lowest set child wins in every style; an empty group encodes to 0.
  function automatic logic [SPLIT_LOG-1:0] node_enc(input logic [SPLIT-1:0] v);
    logic [SPLIT_LOG-1:0] r;
    logic [SPLIT-1:0]     therm;
    logic [SPLIT-1:0]     first;
    logic [SPLIT-1:0]     lm;
    logic                 found;
    r     = '0;
    therm = '0;
    first = '0;
    lm    = '0;
    found = 1'b0;
    case (IMPLEMENTATION)
      0: begin
        for (int i = 0; i < SPLIT; i++) begin
          if (!found && v[i]) begin
            r     = SPLIT_LOG'(i);
            found = 1'b1;
          end
        end
      end
      1: begin
        therm = v;
        for (int k = 1; k < SPLIT; k++) therm = therm | (therm << 1);
        first = therm & ~(therm << 1);
        for (int i = 0; i < SPLIT; i++) r = r | ({SPLIT_LOG{first[i]}} & SPLIT_LOG'(i));
      end
      2: begin
        for (int i = 0; i < SPLIT; i++) begin
          casez ({found, v[i]})
            2'b01: begin
              r     = SPLIT_LOG'(i);
              found = 1'b1;
            end
            default: ;
          endcase
        end
      end
      3: begin
        for (int b = 0; b < SPLIT_LOG; b++) begin
          lm = '0;
          for (int i = 0; i < SPLIT; i++) begin
            if (((i >> b) & 1) == 1) r[b] = r[b] | (v[i] & ~(|(v & lm)));
            lm[i] = 1'b1;
          end
        end
      end
      default: begin
        for (int i = SPLIT - 1; i >= 0; i--) begin
          if (v[i]) r = SPLIT_LOG'(i);
        end
      end
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0]     w_enc_src;
  logic                 w_tree_vld;
  logic [WIDTH_LOG-1:0] w_tree_idx;

`ifdef ONEHOT_ENC_TREE_IN_REG_EN
  logic [WIDTH-1:0] r_dec_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_dec_vld <= '0;
    else     r_dec_vld <= dec_vld;
  end

  assign w_enc_src = r_dec_vld;
`else
  assign w_enc_src = dec_vld;
`endif

  // Input is zero-padded to SPLIT**LEVELS so missing top-level children read as empty.
  always_comb begin : p_tree
    logic [PW-1:0]        lv;
    logic [PW-1:0]        nv;
    logic [IW-1:0]        li [PW];
    logic [IW-1:0]        ni [PW];
    logic [SPLIT_LOG-1:0] c;
    lv = PW'(w_enc_src);
    nv = '0;
    li = '{default: '0};
    ni = '{default: '0};
    c  = '0;
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      nv = '0;
      ni = '{default: '0};
      for (int n = 0; n < PW / SPLIT; n++) begin
        if (n < (PW >> (SPLIT_LOG * (lvl + 1)))) begin
          c             = node_enc(lv[IW'(n * SPLIT) +: SPLIT]);
          nv[IW'(n)]    = |lv[IW'(n * SPLIT) +: SPLIT];
          ni[IW'(n)]    = li[IW'(n * SPLIT + int'(c))] | (IW'(c) << (SPLIT_LOG * lvl));
        end
      end
      lv = nv;
      li = ni;
    end
    w_tree_vld = lv[0];
    w_tree_idx = WIDTH_LOG'(li[0]);
  end

  logic                 r_enc_vld;
  logic [WIDTH_LOG-1:0] r_enc_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_enc_vld <= 1'b0;
      r_enc_idx <= '0;
    end else begin
      r_enc_vld <= w_tree_vld;
      r_enc_idx <= w_tree_idx;
    end
  end

  assign enc_vld = r_enc_vld;
  assign enc_idx = r_enc_idx;

endmodule

// File: tb/tb_onehot_enc_tree.sv
// tb/tb_onehot_enc_tree.sv - scoreboard bench driving several encoder configurations in lockstep
module tb_onehot_enc_tree;

`ifdef ONEHOT_ENC_TREE_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    int         cyc;
    logic       vld;
    logic [4:0] idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] dec_vld = '0;
  logic [31:0] dec_vld32;
  logic [3:0]  o_idx [7];
  logic        o_vld [7];
  logic [4:0]  o32_idx;
  logic        o32_vld;
  string       names [7] = '{"impl0", "impl1", "impl2", "impl3", "impl4", "split2", "split16"};

  exp_t q[$];
  int   cyc     = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  assign dec_vld32 = {dec_vld, dec_vld};

  for (genvar g = 0; g < 5; g++) begin : g_impl
    onehot_enc_tree #(.WIDTH(16), .SPLIT(4), .IMPLEMENTATION(g)) u_dut (
      .clk(clk), .rst(rst), .dec_vld(dec_vld), .enc_idx(o_idx[g]), .enc_vld(o_vld[g]));
  end

  onehot_enc_tree #(.WIDTH(16), .SPLIT(2), .IMPLEMENTATION(0)) u_s2 (
    .clk(clk), .rst(rst), .dec_vld(dec_vld), .enc_idx(o_idx[5]), .enc_vld(o_vld[5]));
  onehot_enc_tree #(.WIDTH(16), .SPLIT(16), .IMPLEMENTATION(0)) u_s16 (
    .clk(clk), .rst(rst), .dec_vld(dec_vld), .enc_idx(o_idx[6]), .enc_vld(o_vld[6]));
  onehot_enc_tree #(.WIDTH(32), .SPLIT(4), .IMPLEMENTATION(0)) u_w32 (
    .clk(clk), .rst(rst), .dec_vld(dec_vld32), .enc_idx(o32_idx), .enc_vld(o32_vld));

  task automatic chk(input string nm, input logic v, input logic [4:0] i,
                     input logic ev, input logic [4:0] ei);
    n_checks++;
    if (v !== ev || i !== ei) begin
      n_fail++;
      $display("FAIL %s: got vld=%0b idx=%0d, expected vld=%0b idx=%0d", nm, v, i, ev, ei);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [4:0] ei);
    for (int g = 0; g < 7; g++) chk($sformatf("%s/%s", tag, names[g]), o_vld[g], {1'b0, o_idx[g]}, ev, ei);
    chk($sformatf("%s/w32", tag), o32_vld, o32_idx, ev, ei);
  endtask

  task automatic push(input int at, input logic ev, input int ei);
    exp_t e;
    e.cyc = at;
    e.vld = ev;
    e.idx = 5'(ei);
    q.push_back(e);
  endtask

  task automatic drive(input logic [15:0] v, input logic ev, input int ei);
    @(negedge clk);
    dec_vld = v;
    push(cyc + LAT, ev, ei);
  endtask

  // Releases reset; with an input stage the first edge still shows the cleared register.
  task automatic release_rst(input logic [15:0] v, input logic ev, input int ei);
    @(negedge clk);
    rst     = 1'b0;
    dec_vld = v;
    if (LAT == 2) push(cyc + 1, 1'b0, 0);
    push(cyc + LAT, ev, ei);
  endtask

  always @(posedge clk) begin : p_monitor
    exp_t e;
    cyc++;
    #1;
    if (!rst) begin
      while (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk_all($sformatf("cyc%0d", cyc), e.vld, e.idx);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    #1;
    chk_all("reset", 1'b0, 5'd0);
    repeat (2) @(negedge clk);
    release_rst(16'h0000, 1'b0, 0);
    drive(16'h0000, 1'b0, 0);

    for (int i = 0; i < 16; i++) drive(16'(1 << i), 1'b1, i);

    drive(16'hA050, 1'b1, 4);
    drive(16'h8001, 1'b1, 0);
    drive(16'hFFFF, 1'b1, 0);
    drive(16'h8000, 1'b1, 15);

    drive(16'h0008, 1'b1, 3);
    drive(16'h1000, 1'b1, 12);
    drive(16'h0000, 1'b0, 0);
    drive(16'h0080, 1'b1, 7);

    drive(16'h0100, 1'b1, 8);
    @(posedge clk);
    #3;
    rst = 1'b1;
    q.delete();
    #1;
    chk_all("async_reset", 1'b0, 5'd0);
    release_rst(16'h0100, 1'b1, 8);
    drive(16'h0020, 1'b1, 5);
    drive(16'h0600, 1'b1, 9);

    repeat (LAT + 2) @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected responses never matched, expected 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
